uart_wb_bridge: RTL and testbench
=================================

# uart_wb_bridge

UART-to-Wishbone debug bridge: a Wishbone bus initiator driven by a host over a serial 8N1 link. It decodes read and write command frames, runs single 32-bit Wishbone cycles on the SoC bus, and serializes the result back to the host. It attaches as a second master on the peripheral bus and reaches the same slaves as the CPU, including the UART, PWM and GPIO blocks, for bring-up without firmware.

## Interface
- CLK_FREQ, 50_000_000: clock frequency in Hz.
- BAUD, 115200: serial rate. BAUD_DIV = CLK_FREQ/BAUD, 16-bit, fixed at elaboration; must be ≥ 4.
- WB_TIMEOUT, 255: maximum wait cycles for wb_ack, used only when the timeout feature is compiled in.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- uart_rx  in  1  serial input from the host; idle high; asynchronous.
- uart_tx  out  1  serial output to the host; idle high.
- wb_cyc, wb_stb  out  1 each  bus cycle / strobe; always asserted together.
- wb_we  out  1  1 = write.
- wb_addr  out  32  byte address.
- wb_dat_o  out  32  write data.
- wb_sel  out  4  byte enables; always 4'hF while wb_stb is high.
- wb_dat_i  in  32  read data.
- wb_ack  in  1  slave acknowledge.
- busy  out  1  high from the first accepted command byte until the last response stop bit ends.

## Operation
- RX path:
  - uart_rx passes through a 2-flop synchronizer.
  - A low level while RX is idle starts a frame.
  - The start bit is re-checked at BAUD_DIV/2 cycles; if it is high, RX returns to idle.
  - Data bits are sampled every BAUD_DIV cycles after that point, LSB first.
  - The stop bit is sampled one BAUD_DIV later. A low stop bit is a frame error: the byte is discarded and the parser returns to IDLE.
- Command frames, multi-byte fields big-endian:
  - 0x52 'R' + 4 address bytes.
  - 0x57 'W' + 4 address bytes + 4 data bytes.
  - Any other first byte is ignored; the parser stays in IDLE.
- Parser FSM:
  - IDLE → ADDR on a valid command byte.
  - ADDR (4 bytes) → BUS for 'R', or → DATA for 'W'.
  - DATA (4 bytes) → BUS.
  - BUS → RESP when wb_ack is sampled high, or on timeout.
  - RESP → IDLE after the last stop bit is sent.
- Bytes received while in BUS or RESP are dropped.
- Responses:
  - Write success: 1 byte 0x4B 'K'.
  - Read success: 4 bytes, data MSB first.
  - Timeout: 1 byte 0x45 'E'.
- TX frame: start bit, 8 data bits LSB first, stop bit; each bit lasts exactly BAUD_DIV cycles. Multi-byte responses are sent back-to-back with no idle gap.
- Reset values: uart_tx=1; wb_cyc=wb_stb=wb_we=0; wb_addr=wb_dat_o=0; wb_sel=0; busy=0; FSM in IDLE; all counters 0.
- Reset asserted mid-operation aborts immediately, including any in-flight bus cycle. No partial response is sent after release.

## Timing
- wb_cyc/wb_stb rise 1 cycle after the stop-bit sample of the last command byte.
- wb_addr, wb_we and wb_dat_o are stable for the whole cycle.
- Strobes stay high until wb_ack is sampled high, then drop on the next edge. Every cycle is exactly one transfer; there are no back-to-back bus cycles.
- wb_dat_i is captured on the edge where wb_ack=1.
- The uart_tx start bit begins 1 cycle after the strobes drop.
- busy falls on the same edge the final stop bit ends.
- wb_ack arriving when wb_stb is low is ignored.

## Configuration
- UART_WB_BRIDGE_TIMEOUT_EN defined:
  - A 16-bit counter increments each cycle wb_stb=1 and wb_ack=0.
  - When it reaches WB_TIMEOUT, the strobes drop on the next edge and 'E' is sent.
  - A wb_ack on the same cycle the limit is reached takes precedence: normal response.
- Macro undefined: no counter; the bridge waits on wb_ack indefinitely and 'E' is never produced.

## Test plan
Bench parameters: CLK_FREQ=1_000_000, BAUD=100_000, so BAUD_DIV=10.
- Write: send 57 00 02 05 0C 00 00 01 B2, slave acks after 2 cycles → one cycle with wb_we=1, addr 0x0002050C, dat_o 0x000001B2, sel F; then uart_tx returns 0x4B with 10-cycle bits.
- Read: send 52 00 02 05 04, slave returns 0xDEADBEEF → uart_tx returns DE AD BE EF with no gaps; busy low after the last stop bit.
- Junk and frame error: send 0x00, then 0x52 with its stop bit forced low, then a valid read → no bus cycle for the junk or the bad frame; the valid read completes normally.
- Timeout, macro defined, WB_TIMEOUT=20, slave never acks → stb high exactly 20 cycles, then 0x45 sent. Macro undefined → stb stays high through 1000 cycles and uart_tx stays idle.
- Reset mid-BUS: assert rst_n low while wb_stb=1 → stb, cyc and busy go 0 and uart_tx goes 1 asynchronously; a later valid read works.
- Bytes sent during RESP are dropped: a second 'R' frame overlapping the response produces no bus cycle.

Source files
------------

// File: rtl/uart_wb_bridge.sv
`default_nettype none
// ============================================================================
// uart_wb_bridge : host-driven Wishbone initiator over a UART 8N1 link.
// Optional ack timeout via `define UART_WB_BRIDGE_TIMEOUT_EN.  Rev 1.0
// ============================================================================
module uart_wb_bridge #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int WB_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic        wb_cyc,
  output logic        wb_stb,
  output logic        wb_we,
  output logic [31:0] wb_addr,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack,
  output logic        busy
);

  localparam logic [15:0] c_baud_div = 16'(CLK_FREQ / BAUD);
  localparam logic [15:0] c_half_div = 16'(CLK_FREQ / BAUD / 2);
`ifdef UART_WB_BRIDGE_TIMEOUT_EN
  localparam logic [15:0] c_to_last  = 16'(WB_TIMEOUT - 1);
`endif

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_BUS, ST_RESP} st_t;

  rx_state_t   r_rx_state;
  logic        r_rx_meta, r_rx_sync;
  logic [15:0] r_rx_cnt;
  logic [2:0]  r_rx_bit;
  logic [7:0]  r_rx_shift;
  logic        r_rx_valid, r_rx_ferr;

  st_t         r_state;
  logic [1:0]  r_byte_cnt;
  logic        r_we, r_cyc, r_busy, r_tx;
  logic [3:0]  r_sel;
  logic [31:0] r_addr, r_wdat, r_resp;
  logic [1:0]  r_tx_left;
  logic [3:0]  r_tx_bit;
  logic [15:0] r_tx_cnt;
`ifdef UART_WB_BRIDGE_TIMEOUT_EN
  logic [15:0] r_to_cnt;
`endif

  logic [7:0]  w_tx_byte;
  logic [2:0]  w_tx_idx;
  logic        w_tx_val;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_meta  <= 1'b1;
      r_rx_sync  <= 1'b1;
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
      r_rx_valid <= 1'b0;
      r_rx_ferr  <= 1'b0;
    end else begin
      r_rx_meta  <= uart_rx;
      r_rx_sync  <= r_rx_meta;
      r_rx_valid <= 1'b0;
      r_rx_ferr  <= 1'b0;
      case (r_rx_state)
        RX_IDLE: begin
          r_rx_cnt <= '0;
          if (!r_rx_sync) r_rx_state <= RX_START;
        end
        RX_START: begin
          if (r_rx_cnt == c_half_div - 16'd1) begin
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_state <= r_rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            r_rx_cnt <= r_rx_cnt + 16'd1;
          end
        end
        RX_DATA: begin
          if (r_rx_cnt == c_baud_div - 16'd1) begin
            r_rx_cnt   <= '0;
            r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
            r_rx_bit   <= r_rx_bit + 3'd1;
            if (r_rx_bit == 3'd7) r_rx_state <= RX_STOP;
          end else begin
            r_rx_cnt <= r_rx_cnt + 16'd1;
          end
        end
        RX_STOP: begin
          if (r_rx_cnt == c_baud_div - 16'd1) begin
            r_rx_cnt   <= '0;
            r_rx_state <= RX_IDLE;
            r_rx_valid <= r_rx_sync;
            r_rx_ferr  <= ~r_rx_sync;
          end else begin
            r_rx_cnt <= r_rx_cnt + 16'd1;
          end
        end
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

  // Bit index 0 is the start bit, 1..8 data LSB first, 9 the stop bit.
  assign w_tx_byte = r_resp[31:24];
  always_comb begin
    w_tx_idx = 3'(r_tx_bit - 4'd1);
    w_tx_val = 1'b1;
    if (r_tx_bit == 4'd0)      w_tx_val = 1'b0;
    else if (r_tx_bit <= 4'd8) w_tx_val = w_tx_byte[w_tx_idx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_byte_cnt <= '0;
      r_we       <= 1'b0;
      r_cyc      <= 1'b0;
      r_sel      <= '0;
      r_busy     <= 1'b0;
      r_tx       <= 1'b1;
      r_addr     <= '0;
      r_wdat     <= '0;
      r_resp     <= '0;
      r_tx_left  <= '0;
      r_tx_bit   <= '0;
      r_tx_cnt   <= '0;
`ifdef UART_WB_BRIDGE_TIMEOUT_EN
      r_to_cnt   <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (r_rx_valid && (r_rx_shift == 8'h52 || r_rx_shift == 8'h57)) begin
            r_we       <= (r_rx_shift == 8'h57);
            r_byte_cnt <= '0;
            r_busy     <= 1'b1;
            r_state    <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (r_rx_ferr) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else if (r_rx_valid) begin
            r_addr     <= {r_addr[23:0], r_rx_shift};
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (r_byte_cnt == 2'd3) begin
              if (r_we) begin
                r_state <= ST_DATA;
              end else begin
                r_state <= ST_BUS;
                r_cyc   <= 1'b1;
                r_sel   <= 4'hF;
              end
            end
          end
        end
        ST_DATA: begin
          if (r_rx_ferr) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else if (r_rx_valid) begin
            r_wdat     <= {r_wdat[23:0], r_rx_shift};
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (r_byte_cnt == 2'd3) begin
              r_state <= ST_BUS;
              r_cyc   <= 1'b1;
              r_sel   <= 4'hF;
            end
          end
        end
        ST_BUS: begin
          if (wb_ack) begin
            r_cyc     <= 1'b0;
            r_sel     <= '0;
            r_resp    <= r_we ? {8'h4B, 24'h0} : wb_dat_i;
            r_tx_left <= r_we ? 2'd0 : 2'd3;
            r_tx_bit  <= '0;
            r_tx_cnt  <= '0;
            r_state   <= ST_RESP;
`ifdef UART_WB_BRIDGE_TIMEOUT_EN
            r_to_cnt  <= '0;
          end else if (r_to_cnt == c_to_last) begin
            r_cyc     <= 1'b0;
            r_sel     <= '0;
            r_resp    <= {8'h45, 24'h0};
            r_tx_left <= 2'd0;
            r_tx_bit  <= '0;
            r_tx_cnt  <= '0;
            r_to_cnt  <= '0;
            r_state   <= ST_RESP;
          end else begin
            r_to_cnt <= r_to_cnt + 16'd1;
`endif
          end
        end
        ST_RESP: begin
          // r_tx_cnt counts down the cycles left in the bit currently on the line.
          if (r_tx_cnt != 16'd0) begin
            r_tx_cnt <= r_tx_cnt - 16'd1;
          end else if (r_tx_bit == 4'd10) begin
            if (r_tx_left != 2'd0) begin
              r_tx_left <= r_tx_left - 2'd1;
              r_resp    <= {r_resp[23:0], 8'h00};
              r_tx      <= 1'b0;
              r_tx_bit  <= 4'd1;
              r_tx_cnt  <= c_baud_div - 16'd1;
            end else begin
              r_tx_bit <= '0;
              r_busy   <= 1'b0;
              r_state  <= ST_IDLE;
            end
          end else begin
            r_tx     <= w_tx_val;
            r_tx_bit <= r_tx_bit + 4'd1;
            r_tx_cnt <= c_baud_div - 16'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign uart_tx  = r_tx;
  assign wb_cyc   = r_cyc;
  assign wb_stb   = r_cyc;
  assign wb_we    = r_we;
  assign wb_addr  = r_addr;
  assign wb_dat_o = r_wdat;
  assign wb_sel   = r_sel;
  assign busy     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_wb_bridge.sv
`default_nettype none
// ============================================================================
// tb_uart_wb_bridge : directed self-checking bench for uart_wb_bridge.
// Rev 1.0
// ============================================================================
module tb_uart_wb_bridge;
  localparam int CLK_FREQ   = 1_000_000;
  localparam int BAUD       = 100_000;
  localparam int WB_TIMEOUT = 20;

  logic        clk = 1'b0, rst_n = 1'b0, uart_rx = 1'b1;
  logic        uart_tx, wb_cyc, wb_stb, wb_we, busy;
  logic [31:0] wb_addr, wb_dat_o;
  logic [31:0] wb_dat_i = '0;
  logic [3:0]  wb_sel;
  logic        wb_ack = 1'b0;

  int n_tests = 0, n_fail = 0;
  int ncyc = 0;

  uart_wb_bridge #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .WB_TIMEOUT(WB_TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .uart_rx(uart_rx), .uart_tx(uart_tx),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_addr(wb_addr),
    .wb_dat_o(wb_dat_o), .wb_sel(wb_sel), .wb_dat_i(wb_dat_i), .wb_ack(wb_ack),
    .busy(busy)
  );

  always #5 clk = ~clk;
  initial forever begin @(posedge clk); ncyc++; end

  // Slave: acks ack_delay negedges after the strobe rises; -1 never acks.
  int          ack_delay = -1;
  int          st_cnt = 0;
  bit          stray_ack = 1'b0;
  logic [31:0] rd_data = '0;
  initial forever begin
    @(negedge clk);
    if (stray_ack) begin
      wb_ack = 1'b1;
    end else if (wb_stb === 1'b1 && ack_delay >= 0) begin
      wb_ack = (st_cnt >= ack_delay);
      if (st_cnt >= ack_delay) wb_dat_i = rd_data;
      st_cnt++;
    end else begin
      wb_ack = 1'b0;
      st_cnt = 0;
    end
  end

  // Bus monitor: counts cycles, captures attributes, tracks stability and length.
  int          n_bus = 0, stb_len = 0, fall_cyc = 0;
  bit          prev_stb = 1'b0, unstable = 1'b0;
  logic [68:0] cap = '0;
  initial forever begin
    @(negedge clk);
    if (wb_stb === 1'b1 && !prev_stb) begin
      n_bus++;
      stb_len  = 1;
      unstable = (wb_cyc !== 1'b1);
      cap      = {wb_we, wb_addr, wb_dat_o, wb_sel};
    end else if (wb_stb === 1'b1) begin
      stb_len++;
      if ({wb_we, wb_addr, wb_dat_o, wb_sel} !== cap || wb_cyc !== 1'b1) unstable = 1'b1;
    end else if (prev_stb) begin
      fall_cyc = ncyc;
    end
    prev_stb = (wb_stb === 1'b1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_stop);
    uart_rx = 1'b0;
    repeat (10) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (10) @(posedge clk);
    end
    uart_rx = ~bad_stop;
    repeat (10) @(posedge clk);
    uart_rx = 1'b1;
  endtask

  task automatic send_read(input logic [31:0] a);
    send_byte(8'h52, 1'b0);
    for (int i = 3; i >= 0; i--) send_byte(a[8*i +: 8], 1'b0);
  endtask

  task automatic send_write(input logic [31:0] a, input logic [31:0] d);
    send_byte(8'h57, 1'b0);
    for (int i = 3; i >= 0; i--) send_byte(a[8*i +: 8], 1'b0);
    for (int i = 3; i >= 0; i--) send_byte(d[8*i +: 8], 1'b0);
  endtask

  task automatic wait_tx_low(output bit ok);
    int w = 0;
    do begin @(negedge clk); w++; end while (uart_tx !== 1'b0 && w < 3000);
    ok = (uart_tx === 1'b0);
  endtask

  task automatic wait_stb(output bit ok);
    int w = 0;
    do begin @(negedge clk); w++; end while (wb_stb !== 1'b1 && w < 3000);
    ok = (wb_stb === 1'b1);
  endtask

  // Samples every cycle of the frame; returns on the last stop-bit cycle.
  task automatic recv_byte(output logic [7:0] b, output int t0, output bit ok);
    logic [9:0] bits;
    bit found;
    bits = '1;
    wait_tx_low(found);
    t0 = ncyc;
    ok = found;
    if (found) begin
      for (int k = 0; k < 10; k++) begin
        bits[k] = uart_tx;
        for (int j = 1; j < 10; j++) begin
          @(negedge clk);
          if (uart_tx !== bits[k]) ok = 1'b0;
        end
        if (k < 9) @(negedge clk);
      end
      if (bits[0] !== 1'b0 || bits[9] !== 1'b1) ok = 1'b0;
    end
    b = bits[8:1];
  endtask

  task automatic recv_resp(input string tag, input logic [31:0] exp, input int n, output int t_first);
    logic [31:0] val = '0;
    logic [7:0]  b;
    int          t0, tprev = 0;
    bit          ok, all_ok = 1'b1, gap_ok = 1'b1;
    t_first = 0;
    for (int i = 0; i < n; i++) begin
      recv_byte(b, t0, ok);
      if (!ok) all_ok = 1'b0;
      if (i == 0) t_first = t0;
      else if (t0 != tprev + 100) gap_ok = 1'b0;
      tprev = t0;
      val = {val[23:0], b};
    end
    check_eq({tag, "_frame"}, 32'(all_ok), 32'd1);
    check_eq({tag, "_data"}, val, exp);
    if (n > 1) check_eq({tag, "_nogap"}, 32'(gap_ok), 32'd1);
    check_eq({tag, "_busy_last"}, 32'(busy), 32'd1);
    @(negedge clk);
    check_eq({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
    check_eq({tag, "_tx_idle"}, {31'd0, uart_tx}, 32'd1);
  endtask

  task automatic do_read(input string tag, input logic [31:0] a, input logic [31:0] d);
    int t, n0;
    n0 = n_bus;
    rd_data   = d;
    ack_delay = 1;
    fork
      send_read(a);
      recv_resp(tag, d, 4, t);
    join
    check_eq({tag, "_ncyc"}, 32'(n_bus - n0), 32'd1);
    check_eq({tag, "_addr"}, cap[67:36], a);
    check_eq({tag, "_we"}, {31'd0, cap[68]}, 32'd0);
    check_eq({tag, "_start_lat"}, 32'(t - fall_cyc), 32'd1);
  endtask

  initial begin
    int  t, n0;
    bit  ok;
    // Reset values
    #23;
    check_eq("rst_ctrl", {26'd0, uart_tx, wb_cyc, wb_stb, wb_we, busy, 1'b0}, 32'b100000);
    check_eq("rst_addr", wb_addr, 32'd0);
    check_eq("rst_dat_sel", wb_dat_o | {28'd0, wb_sel}, 32'd0);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);

    // Acknowledge while idle must be ignored
    stray_ack = 1'b1;
    repeat (20) @(negedge clk);
    stray_ack = 1'b0;
    check_eq("stray_ack", {29'd0, busy, uart_tx, 1'b0} | 32'(n_bus), 32'b010);

    // Write
    ack_delay = 2;
    fork
      send_write(32'h0002_050C, 32'h0000_01B2);
      recv_resp("wr", 32'h0000_004B, 1, t);
    join
    check_eq("wr_ncyc", 32'(n_bus), 32'd1);
    check_eq("wr_we", {31'd0, cap[68]}, 32'd1);
    check_eq("wr_addr", cap[67:36], 32'h0002_050C);
    check_eq("wr_dat", cap[35:4], 32'h0000_01B2);
    check_eq("wr_sel", {28'd0, cap[3:0]}, 32'hF);
    check_eq("wr_stable", 32'(unstable), 32'd0);
    check_eq("wr_stb_len", 32'(stb_len), 32'd3);
    check_eq("wr_start_lat", 32'(t - fall_cyc), 32'd1);
    check_eq("wr_sel_idle", {28'd0, wb_sel}, 32'd0);

    // Read
    do_read("rd", 32'h0002_0504, 32'hDEAD_BEEF);

    // Junk byte and a framing error produce no bus cycle
    n0 = n_bus;
    send_byte(8'h00, 1'b0);
    send_byte(8'h52, 1'b1);
    repeat (30) @(negedge clk);
    check_eq("junk_nocyc", 32'(n_bus - n0), 32'd0);
    check_eq("junk_busy", {31'd0, busy}, 32'd0);
    do_read("rd2", 32'h0000_0010, 32'h1234_5678);

    // Command sent while the response is going out is dropped
    n0 = n_bus;
    rd_data   = 32'hCAFE_F00D;
    ack_delay = 1;
    fork
      begin
        send_read(32'h0000_0200);
        wait_tx_low(ok);
        send_byte(8'h52, 1'b0);
        repeat (4) send_byte(8'h00, 1'b0);
      end
      recv_resp("ovl", 32'hCAFE_F00D, 4, t);
    join
    repeat (20) @(negedge clk);
    check_eq("ovl_ncyc", 32'(n_bus - n0), 32'd1);
    check_eq("ovl_busy", {31'd0, busy}, 32'd0);

`ifdef UART_WB_BRIDGE_TIMEOUT_EN
    // Timeout: strobe held for WB_TIMEOUT cycles, then 'E'
    ack_delay = -1;
    fork
      send_read(32'h0000_0044);
      recv_resp("to", 32'h0000_0045, 1, t);
    join
    check_eq("to_stb_len", 32'(stb_len), 32'd20);
`endif

    // Reset mid-bus cycle aborts asynchronously
    ack_delay = -1;
    send_read(32'h0000_0100);
    wait_stb(ok);
    check_eq("hang_stb_seen", 32'(ok), 32'd1);
`ifdef UART_WB_BRIDGE_TIMEOUT_EN
    repeat (5) @(negedge clk);
`else
    begin
      int hi = 0;
      repeat (1000) begin
        @(negedge clk);
        if (wb_stb === 1'b1 && uart_tx === 1'b1) hi++;
      end
      check_eq("hang_1000", 32'(hi), 32'd1000);
    end
`endif
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_async", {28'd0, wb_stb, wb_cyc, busy, uart_tx}, 32'b0001);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check_eq("rst_no_resp", {30'd0, uart_tx, busy}, 32'b10);
    do_read("rd3", 32'h0000_0300, 32'hA5C3_0F96);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    n_tests++;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1);
  end
endmodule
`default_nettype wire
